// File: rtl/module_adder_pipe.sv
// Pipelined unsigned add/subtract with valid/ready handshakes; the carry chain is cut into STAGES chunks.
// Optional unsigned saturation in the final stage is enabled with macro ADDER_PIPE_SAT_EN.
module module_adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_pi,
    input  logic             rst_n_pi,
    input  logic             valid_pi,
    output logic             ready_po,
    input  logic [WIDTH-1:0] a_pi,
    input  logic [WIDTH-1:0] b_pi,
    input  logic             sub_pi,
    output logic             valid_po,
    input  logic             ready_pi,
    output logic [WIDTH-1:0] result_po,
    output logic             carry_po
);
    localparam int CW = WIDTH / STAGES;

    logic adv_s;

    assign adv_s    = ~valid_po | ready_pi;
    assign ready_po = adv_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // IW operand bits arrive at this stage, OW of them are still unconsumed afterwards
        localparam int LO = k * CW;
        localparam int IW = WIDTH - LO;
        localparam int OW = IW - CW;
        localparam int RW = LO + CW;

        logic          in_v_s;
        logic          in_sub_s;
        logic          in_cin_s;
        logic [IW-1:0] in_a_s;
        logic [IW-1:0] in_b_s;
        logic [CW:0]   sum_s;
        logic [RW-1:0] res_s;
        logic [RW-1:0] fin_s;
        logic          vld_d, vld_q;
        logic          cy_d, cy_q;
        logic [RW-1:0] res_d, res_q;

        if (k == 0) begin : g_head
            assign in_v_s   = valid_pi;
            assign in_sub_s = sub_pi;
            assign in_cin_s = sub_pi;
            assign in_a_s   = a_pi;
            assign in_b_s   = b_pi;
            assign res_s    = sum_s[CW-1:0];
        end else begin : g_link
            assign in_v_s   = g_stg[k-1].vld_q;
            assign in_sub_s = g_stg[k-1].g_op.sub_q;
            assign in_cin_s = g_stg[k-1].cy_q;
            assign in_a_s   = g_stg[k-1].g_op.a_q;
            assign in_b_s   = g_stg[k-1].g_op.b_q;
            assign res_s    = {sum_s[CW-1:0], g_stg[k-1].res_q};
        end

        assign sum_s = {1'b0, in_a_s[CW-1:0]}
                     + {1'b0, in_b_s[CW-1:0] ^ {CW{in_sub_s}}}
                     + {{CW{1'b0}}, in_cin_s};

`ifdef ADDER_PIPE_SAT_EN
        if (k == STAGES - 1) begin : g_sat
            // clamp on unsigned overflow (add) or borrow (sub); carry stays raw
            assign fin_s = (in_sub_s & ~sum_s[CW]) ? {RW{1'b0}} :
                           ((~in_sub_s & sum_s[CW]) ? {RW{1'b1}} : res_s);
        end else begin : g_nosat
            assign fin_s = res_s;
        end
`else
        assign fin_s = res_s;
`endif

        // stage next-state: shift forward on adv, otherwise hold
        always_comb begin
            vld_d = vld_q;
            cy_d  = cy_q;
            res_d = res_q;
            if (adv_s) begin
                vld_d = in_v_s;
                cy_d  = sum_s[CW];
                res_d = fin_s;
            end else begin
                vld_d = vld_q;
                cy_d  = cy_q;
                res_d = res_q;
            end
        end

        // stage valid, carry and partial-result registers
        always_ff @(posedge clk_pi or negedge rst_n_pi) begin
            if (!rst_n_pi) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                res_q <= {RW{1'b0}};
            end else begin
                vld_q <= vld_d;
                cy_q  <= cy_d;
                res_q <= res_d;
            end
        end

        if (OW > 0) begin : g_op
            logic          sub_d, sub_q;
            logic [OW-1:0] a_d, a_q;
            logic [OW-1:0] b_d, b_q;

            // upper operand chunks and op select travel with their partial result
            always_comb begin
                sub_d = sub_q;
                a_d   = a_q;
                b_d   = b_q;
                if (adv_s) begin
                    sub_d = in_sub_s;
                    a_d   = in_a_s[IW-1:CW];
                    b_d   = in_b_s[IW-1:CW];
                end else begin
                    sub_d = sub_q;
                    a_d   = a_q;
                    b_d   = b_q;
                end
            end

            // delayed operand registers
            always_ff @(posedge clk_pi or negedge rst_n_pi) begin
                if (!rst_n_pi) begin
                    sub_q <= 1'b0;
                    a_q   <= {OW{1'b0}};
                    b_q   <= {OW{1'b0}};
                end else begin
                    sub_q <= sub_d;
                    a_q   <= a_d;
                    b_q   <= b_d;
                end
            end
        end
    end

    assign valid_po  = g_stg[STAGES-1].vld_q;
    assign result_po = g_stg[STAGES-1].res_q;
    assign carry_po  = g_stg[STAGES-1].cy_q;

endmodule

// File: tb/tb_module_adder_pipe.sv
// Bench for module_adder_pipe: drives an 8-bit/2-stage and a 32-bit/4-stage instance in lockstep
// from a vector table plus random traffic, with per-instance scoreboards.
module tb_module_adder_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy_i;
    logic [31:0] a_s, b_s;
    logic        sub_s;
    logic        v8, v32;
    logic        rdy8, vo8, c8;
    logic [7:0]  r8;
    logic        rdy32, vo32, c32;
    logic [31:0] r32;

    always #5 clk = ~clk;

    module_adder_pipe #(.WIDTH(8), .STAGES(2)) u8 (
        .clk_pi(clk), .rst_n_pi(rst_n), .valid_pi(v8), .ready_po(rdy8),
        .a_pi(a_s[7:0]), .b_pi(b_s[7:0]), .sub_pi(sub_s), .valid_po(vo8),
        .ready_pi(rdy_i), .result_po(r8), .carry_po(c8)
    );

    module_adder_pipe #(.WIDTH(32), .STAGES(4)) u32 (
        .clk_pi(clk), .rst_n_pi(rst_n), .valid_pi(v32), .ready_po(rdy32),
        .a_pi(a_s), .b_pi(b_s), .sub_pi(sub_s), .valid_po(vo32),
        .ready_pi(rdy_i), .result_po(r32), .carry_po(c32)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] r8;
        logic        c8;
        logic [31:0] r32;
        logic        c32;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic        c;
        int          cyc;
    } exp_t;

    exp_t        q8[$];
    exp_t        q32[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          lat_en = 1'b1;
    logic [31:0] cur_r8, cur_r32;
    logic        cur_c8, cur_c32;
    logic        held8 = 1'b0, held32 = 1'b0, hc8, hc32;
    logic [31:0] hr8, hr32;
    vec_t        tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_r(input logic [31:0] r, input logic c, input logic sub, input int w);
`ifdef ADDER_PIPE_SAT_EN
        if (!sub && c) return (w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        if (sub && !c) return 32'h0;
`endif
        return r;
    endfunction

    function automatic logic [32:0] mdl8(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [8:0] t;
        t = {1'b0, a[7:0]} + {1'b0, (sub ? ~b[7:0] : b[7:0])} + {8'd0, sub};
        return {t[8], sat_r({24'd0, t[7:0]}, t[8], sub, 8)};
    endfunction

    function automatic logic [32:0] mdl32(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] t;
        t = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {32'd0, sub};
        return {t[32], sat_r(t[31:0], t[32], sub, 32)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard and output-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            held8  <= 1'b0;
            held32 <= 1'b0;
        end else begin
            if (held8) begin
                chk("hold_valid8", {31'd0, vo8}, 32'd1);
                chk("hold_res8", {24'd0, r8}, hr8);
                chk("hold_carry8", {31'd0, c8}, {31'd0, hc8});
            end
            if (held32) begin
                chk("hold_valid32", {31'd0, vo32}, 32'd1);
                chk("hold_res32", r32, hr32);
                chk("hold_carry32", {31'd0, c32}, {31'd0, hc32});
            end
            if (vo8 && !rdy_i) chk("stall_ready8", {31'd0, rdy8}, 32'd0);
            if (vo32 && !rdy_i) chk("stall_ready32", {31'd0, rdy32}, 32'd0);
            if (v8 && rdy8) q8.push_back('{cur_r8, cur_c8, cyc});
            if (v32 && rdy32) q32.push_back('{cur_r32, cur_c32, cyc});
            if (vo8 && rdy_i) begin
                if (q8.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious8: got result 0x%0h, expected no output", r8);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    chk("res8", {24'd0, r8}, e.r);
                    chk("carry8", {31'd0, c8}, {31'd0, e.c});
                    if (lat_en) chk("latency8", cyc - e.cyc, 32'd2);
                end
            end
            if (vo32 && rdy_i) begin
                if (q32.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious32: got result 0x%0h, expected no output", r32);
                end else begin
                    exp_t e;
                    e = q32.pop_front();
                    chk("res32", r32, e.r);
                    chk("carry32", {31'd0, c32}, {31'd0, e.c});
                    if (lat_en) chk("latency32", cyc - e.cyc, 32'd4);
                end
            end
            held8  <= vo8 && !rdy_i;
            hr8    <= {24'd0, r8};
            hc8    <= c8;
            held32 <= vo32 && !rdy_i;
            hr32   <= r32;
            hc32   <= c32;
        end
    end

    // present one operand set to both units until each has accepted it
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [31:0] e8, input logic ec8, input logic [31:0] e32, input logic ec32);
        logic acc8, acc32;
        a_s = a; b_s = b; sub_s = sub;
        cur_r8 = e8; cur_c8 = ec8; cur_r32 = e32; cur_c32 = ec32;
        v8 = 1'b1; v32 = 1'b1;
        for (int i = 0; i < 60 && (v8 || v32); i++) begin
            @(negedge clk);
            acc8  = v8 && rdy8;
            acc32 = v32 && rdy32;
            @(posedge clk);
            #1;
            if (acc8) v8 = 1'b0;
            if (acc32) v32 = 1'b0;
        end
        if (v8 || v32) begin
            tests++; fails++;
            $display("FAIL send_timeout: got pending v8=%0b v32=%0b, expected both accepted", v8, v32);
            v8 = 1'b0; v32 = 1'b0;
        end
    endtask

    task automatic send_m(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] e8, e32;
        e8  = mdl8(a, b, sub);
        e32 = mdl32(a, b, sub);
        send(a, b, sub, e8[31:0], e8[32], e32[31:0], e32[32]);
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (q8.size() != 0 || q32.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain8", q8.size(), 32'd0);
        chk("drain32", q32.size(), 32'd0);
    endtask

    initial begin
        bit done;
        rst_n = 1'b0; rdy_i = 1'b1; v8 = 1'b0; v32 = 1'b0;
        a_s = 32'd0; b_s = 32'd0; sub_s = 1'b0;
        cur_r8 = 32'd0; cur_r32 = 32'd0; cur_c8 = 1'b0; cur_c32 = 1'b0;

        tbl[0]  = '{32'h0000_007F, 32'h0000_0001, 1'b0, 32'h80, 1'b0, 32'h0000_0080, 1'b0};
        tbl[1]  = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h00, 1'b1, 32'h0000_0100, 1'b0};
        tbl[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFE, 1'b0, 32'hFFFF_FFFE, 1'b0};
        tbl[3]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h02, 1'b1, 32'h0000_0002, 1'b1};
        tbl[4]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h00, 1'b1, 32'h0000_0000, 1'b1};
        tbl[5]  = '{32'h1234_5678, 32'h1111_1111, 1'b1, 32'h67, 1'b1, 32'h0123_4567, 1'b1};
        tbl[6]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h00, 1'b1, 32'h0001_0000, 1'b0};
        tbl[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h00, 1'b1, 32'h0000_0000, 1'b1};
        tbl[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h00, 1'b0, 32'h0000_0000, 1'b1};
        tbl[9]  = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h00, 1'b1, 32'h0100_0100, 1'b0};
        tbl[10] = '{32'h0100_0000, 32'h0000_0001, 1'b1, 32'hFF, 1'b0, 32'h00FF_FFFF, 1'b1};
        tbl[11] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'hFF, 1'b0, 32'hFFFF_FFFF, 1'b0};

        #12;
        chk("rst_valid8", {31'd0, vo8}, 32'd0);
        chk("rst_res8", {24'd0, r8}, 32'd0);
        chk("rst_carry8", {31'd0, c8}, 32'd0);
        chk("rst_valid32", {31'd0, vo32}, 32'd0);
        chk("rst_res32", r32, 32'd0);
        chk("rst_carry32", {31'd0, c32}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("ready8_after_rst", {31'd0, rdy8}, 32'd1);
        chk("ready32_after_rst", {31'd0, rdy32}, 32'd1);

        // isolated transfer, then the whole table back-to-back at full rate
        send(tbl[0].a, tbl[0].b, tbl[0].sub, sat_r(tbl[0].r8, tbl[0].c8, tbl[0].sub, 8), tbl[0].c8,
             sat_r(tbl[0].r32, tbl[0].c32, tbl[0].sub, 32), tbl[0].c32);
        drain();
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].sub,
                 sat_r(tbl[i].r8, tbl[i].c8, tbl[i].sub, 8), tbl[i].c8,
                 sat_r(tbl[i].r32, tbl[i].c32, tbl[i].sub, 32), tbl[i].c32);
        end
        drain();

        // backpressure: output stalled while the producer keeps offering data
        lat_en = 1'b0;
        rdy_i  = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_m($urandom, $urandom, 1'(i % 2));
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("bp_valid8", {31'd0, vo8}, 32'd1);
                chk("bp_ready8", {31'd0, rdy8}, 32'd0);
                chk("bp_valid32", {31'd0, vo32}, 32'd1);
                chk("bp_ready32", {31'd0, rdy32}, 32'd0);
                @(posedge clk);
                #1 rdy_i = 1'b1;
            end
        join
        drain();

        // random traffic with random output backpressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 16; i++) send_m($urandom, $urandom, 1'($urandom_range(0, 1)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 rdy_i = 1'($urandom_range(0, 1));
                end
            end
        join
        rdy_i = 1'b1;
        drain();

        // reset with results in flight
        send_m(32'h0000_0011, 32'h0000_0022, 1'b0);
        send_m(32'h0000_0033, 32'h0000_0044, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid8", {31'd0, vo8}, 32'd0);
        chk("midrst_res8", {24'd0, r8}, 32'd0);
        chk("midrst_valid32", {31'd0, vo32}, 32'd0);
        chk("midrst_res32", r32, 32'd0);
        q8.delete();
        q32.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("postrst_valid8", {31'd0, vo8}, 32'd0);
        chk("postrst_valid32", {31'd0, vo32}, 32'd0);

        send_m(32'h0000_00FF, 32'h0000_0001, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
